// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the RISC-V core: captures decoded fields, interlocks on
// load-use hazards, and forwards EX/MEM and MEM/WB results into the ALU operands.
module ex_operand_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic [4:0]              id_rd,
  input  logic [DATA_WIDTH-1:0]   id_rs1_data,
  input  logic [DATA_WIDTH-1:0]   id_rs2_data,
  input  logic [DATA_WIDTH-1:0]   id_imm,
  input  logic                    id_alu_src,
  input  logic [ALU_OP_WIDTH-1:0] id_alu_op,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    exmem_reg_write,
  input  logic [4:0]              exmem_rd,
  input  logic [DATA_WIDTH-1:0]   exmem_result,
  input  logic                    memwb_reg_write,
  input  logic [4:0]              memwb_rd,
  input  logic [DATA_WIDTH-1:0]   memwb_result,
  output logic                    id_hold,
  output logic                    ex_valid,
  output logic [ALU_OP_WIDTH-1:0] alu_operation,
  output logic [DATA_WIDTH-1:0]   alu_in_1,
  output logic [DATA_WIDTH-1:0]   alu_in_2,
  output logic [DATA_WIDTH-1:0]   ex_store_data,
  output logic [4:0]              ex_rd,
  output logic                    ex_reg_write,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write
);

  localparam logic [ALU_OP_WIDTH-1:0] FUNC_ZERO = '0;

  logic                           vld_p1;
  logic [4:0]                     rs1_p1;
  logic [4:0]                     rs2_p1;
  logic [4:0]                     rd_p1;
  logic signed [DATA_WIDTH-1:0]   rs1_data_p1;
  logic signed [DATA_WIDTH-1:0]   rs2_data_p1;
  logic signed [DATA_WIDTH-1:0]   imm_p1;
  logic                           alu_src_p1;
  logic [ALU_OP_WIDTH-1:0]        alu_op_p1;
  logic                           reg_write_p1;
  logic                           mem_read_p1;
  logic                           mem_write_p1;

  logic                           load_use;
  logic signed [DATA_WIDTH-1:0]   fwd_rs1;
  logic signed [DATA_WIDTH-1:0]   fwd_rs2;

  // EX/MEM is newer than MEM/WB, so it is checked first; x0 is never forwarded.
  function automatic logic signed [DATA_WIDTH-1:0] fwd_operand(
    input logic [4:0]                   src,
    input logic signed [DATA_WIDTH-1:0] reg_data,
    input logic                         em_wr,
    input logic [4:0]                   em_rd,
    input logic [DATA_WIDTH-1:0]        em_res,
    input logic                         mw_wr,
    input logic [4:0]                   mw_rd,
    input logic [DATA_WIDTH-1:0]        mw_res
  );
    if (em_wr && em_rd != 5'd0 && em_rd == src)
      return signed'(em_res);
    else if (mw_wr && mw_rd != 5'd0 && mw_rd == src)
      return signed'(mw_res);
    else
      return reg_data;
  endfunction

  // Conservative: an immediate-form consumer of rs2 still interlocks.
  assign load_use = vld_p1 & mem_read_p1 & (rd_p1 != 5'd0) & id_valid &
                    ((id_rs1 == rd_p1) | (id_rs2 == rd_p1));

  assign id_hold = (stall | load_use) & ~flush & ~reset;

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && load_use)) begin
      vld_p1       <= 1'b0;
      rs1_p1       <= 5'd0;
      rs2_p1       <= 5'd0;
      rd_p1        <= 5'd0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
      alu_op_p1    <= FUNC_ZERO;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1       <= id_valid;
      rs1_p1       <= id_rs1;
      rs2_p1       <= id_rs2;
      rd_p1        <= id_rd;
      rs1_data_p1  <= signed'(id_rs1_data);
      rs2_data_p1  <= signed'(id_rs2_data);
      imm_p1       <= signed'(id_imm);
      alu_src_p1   <= id_valid & id_alu_src;
      alu_op_p1    <= id_valid ? id_alu_op : FUNC_ZERO;
      reg_write_p1 <= id_valid & id_reg_write;
      mem_read_p1  <= id_valid & id_mem_read;
      mem_write_p1 <= id_valid & id_mem_write;
    end
  end

  assign fwd_rs1 = fwd_operand(rs1_p1, rs1_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result);
  assign fwd_rs2 = fwd_operand(rs2_p1, rs2_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result);

  assign alu_in_1      = vld_p1 ? fwd_rs1 : '0;
  assign alu_in_2      = vld_p1 ? (alu_src_p1 ? imm_p1 : fwd_rs2) : '0;
  assign ex_store_data = vld_p1 ? fwd_rs2 : '0;
  assign alu_operation = alu_op_p1;
  assign ex_valid      = vld_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding priority, load-use interlock,
// stall/flush/reset priority and store data forwarding.
module tb_ex_operand_stage;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam logic [OW-1:0] FUNC_ZERO = 4'h0;
  localparam logic [OW-1:0] OP_ADD    = 4'h1;
  localparam logic [OW-1:0] OP_SUB    = 4'h2;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic          id_alu_src;
  logic [OW-1:0] id_alu_op;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          stall, flush;
  logic          exmem_reg_write;
  logic [4:0]    exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [4:0]    memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          id_hold, ex_valid;
  logic [OW-1:0] alu_operation;
  logic [DW-1:0] alu_in_1, alu_in_2, ex_store_data;
  logic [4:0]    ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int passes = 0;

  ex_operand_stage #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .id_hold(id_hold), .ex_valid(ex_valid), .alu_operation(alu_operation),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic [DW-1:0] imm, input logic src, input logic [OW-1:0] op,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_src = src; id_alu_op = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; flush = 0;
    clear_fwd();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 1, OP_ADD, 1, 0, 0);
    step();
    step();
    checks++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", ex_valid); else passes++;
    checks++; if (alu_in_1 !== 32'h0) $display("FAIL reset_in1: got %0h want 0", alu_in_1); else passes++;
    checks++; if (alu_in_2 !== 32'h0) $display("FAIL reset_in2: got %0h want 0", alu_in_2); else passes++;
    checks++; if (alu_operation !== FUNC_ZERO) $display("FAIL reset_op: got %0h want %0h", alu_operation, FUNC_ZERO); else passes++;
    checks++; if (ex_reg_write !== 1'b0) $display("FAIL reset_rw: got %0h want 0", ex_reg_write); else passes++;
    stall = 1;
    #1;
    checks++; if (id_hold !== 1'b0) $display("FAIL reset_hold: got %0h want 0", id_hold); else passes++;
    stall = 0;
    reset = 0;
  endtask

  task automatic test_capture();
    set_id(1, 5'd1, 5'd2, 5'd6, 32'h5, 32'h0, 32'h7, 1, OP_ADD, 1, 0, 0);
    step();
    checks++; if (alu_in_1 !== 32'h5) $display("FAIL cap_in1: got %0h want 5", alu_in_1); else passes++;
    checks++; if (alu_in_2 !== 32'h7) $display("FAIL cap_in2: got %0h want 7", alu_in_2); else passes++;
    checks++; if (alu_operation !== OP_ADD) $display("FAIL cap_op: got %0h want %0h", alu_operation, OP_ADD); else passes++;
    checks++; if (ex_rd !== 5'd6 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1)
      $display("FAIL cap_ctrl: got rd=%0d rw=%0h v=%0h want rd=6 rw=1 v=1", ex_rd, ex_reg_write, ex_valid); else passes++;
    set_id(0, 5'd1, 5'd2, 5'd6, 32'h5, 32'h0, 32'h7, 1, OP_ADD, 1, 1, 1);
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0)
      $display("FAIL cap_invalid_ctrl: got v=%0h rw=%0h mr=%0h mw=%0h want all 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write); else passes++;
    checks++; if (alu_in_1 !== 32'h0) $display("FAIL cap_invalid_in1: got %0h want 0", alu_in_1); else passes++;
  endtask

  task automatic test_forward();
    set_id(1, 5'd3, 5'd0, 5'd7, 32'h33, 32'h44, 32'h0, 0, OP_ADD, 1, 0, 0);
    step();
    set_id(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, FUNC_ZERO, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1;
    checks++; if (alu_in_1 !== 32'h11) $display("FAIL fwd_exmem_wins: got %0h want 11", alu_in_1); else passes++;
    exmem_reg_write = 0;
    #1;
    checks++; if (alu_in_1 !== 32'h22) $display("FAIL fwd_memwb: got %0h want 22", alu_in_1); else passes++;
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h11; memwb_reg_write = 0;
    #1;
    checks++; if (alu_in_1 !== 32'h33) $display("FAIL fwd_x0_rs1: got %0h want 33", alu_in_1); else passes++;
    checks++; if (alu_in_2 !== 32'h44) $display("FAIL fwd_x0_rs2: got %0h want 44", alu_in_2); else passes++;
    clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h0, 1, OP_ADD, 1, 1, 0);
    step();
    set_id(1, 5'd2, 5'd4, 5'd8, 32'h10, 32'h55, 32'h0, 0, OP_ADD, 1, 0, 0);
    #1;
    checks++; if (id_hold !== 1'b1) $display("FAIL lu_hold: got %0h want 1", id_hold); else passes++;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) $display("FAIL lu_bubble: got v=%0h mr=%0h want 0 0", ex_valid, ex_mem_read); else passes++;
    checks++; if (id_hold !== 1'b0) $display("FAIL lu_hold_release: got %0h want 0", id_hold); else passes++;
    step();
    memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 32'hABCD;
    #1;
    checks++; if (alu_in_2 !== 32'hABCD) $display("FAIL lu_fwd_in2: got %0h want abcd", alu_in_2); else passes++;
    checks++; if (alu_in_1 !== 32'h10 || ex_valid !== 1'b1) $display("FAIL lu_enter: got in1=%0h v=%0h want 10 1", alu_in_1, ex_valid); else passes++;
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    set_id(1, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 1, OP_ADD, 1, 1, 0);
    step();
    set_id(1, 5'd4, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 1, OP_ADD, 1, 1, 0);
    #1;
    checks++; if (id_hold !== 1'b1) $display("FAIL b2b_hold1: got %0h want 1", id_hold); else passes++;
    step();
    checks++; if (ex_valid !== 1'b0) $display("FAIL b2b_bubble1: got %0h want 0", ex_valid); else passes++;
    step();
    checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5) $display("FAIL b2b_load2: got mr=%0h rd=%0d want 1 5", ex_mem_read, ex_rd); else passes++;
    set_id(1, 5'd6, 5'd5, 5'd9, 32'h0, 32'h0, 32'h0, 0, OP_SUB, 1, 0, 0);
    #1;
    checks++; if (id_hold !== 1'b1) $display("FAIL b2b_hold2: got %0h want 1", id_hold); else passes++;
    step();
    checks++; if (ex_valid !== 1'b0) $display("FAIL b2b_bubble2: got %0h want 0", ex_valid); else passes++;
    step();
    checks++; if (ex_valid !== 1'b1 || alu_operation !== OP_SUB || ex_rd !== 5'd9)
      $display("FAIL b2b_alu: got v=%0h op=%0h rd=%0d want 1 2 9", ex_valid, alu_operation, ex_rd); else passes++;
    // load to x0 must not interlock
    set_id(1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, OP_ADD, 1, 1, 0);
    step();
    set_id(1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 0, OP_ADD, 1, 0, 0);
    #1;
    checks++; if (id_hold !== 1'b0) $display("FAIL b2b_x0_hold: got %0h want 0", id_hold); else passes++;
  endtask

  task automatic test_stall_flush();
    set_id(1, 5'd1, 5'd0, 5'd9, 32'h77, 32'h0, 32'h12, 1, OP_SUB, 1, 0, 0);
    step();
    set_id(1, 5'd2, 5'd0, 5'd10, 32'hEE, 32'h0, 32'h34, 1, OP_ADD, 1, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_hold !== 1'b1) $display("FAIL stall_hold[%0d]: got %0h want 1", i, id_hold); else passes++;
      step();
      checks++; if (alu_in_1 !== 32'h77 || alu_in_2 !== 32'h12 || ex_rd !== 5'd9 || alu_operation !== OP_SUB)
        $display("FAIL stall_keep[%0d]: got in1=%0h in2=%0h rd=%0d op=%0h want 77 12 9 2", i, alu_in_1, alu_in_2, ex_rd, alu_operation); else passes++;
    end
    flush = 1;
    #1;
    checks++; if (id_hold !== 1'b0) $display("FAIL flush_hold: got %0h want 0", id_hold); else passes++;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) $display("FAIL flush_bubble: got v=%0h rw=%0h want 0 0", ex_valid, ex_reg_write); else passes++;
    flush = 0; stall = 0;
    step();
    checks++; if (alu_in_1 !== 32'hEE) $display("FAIL flush_resume: got %0h want ee", alu_in_1); else passes++;
    stall = 1; reset = 1;
    step();
    checks++; if (ex_valid !== 1'b0 || alu_in_1 !== 32'h0) $display("FAIL reset_mid_stall: got v=%0h in1=%0h want 0 0", ex_valid, alu_in_1); else passes++;
    stall = 0; reset = 0;
  endtask

  task automatic test_store();
    set_id(1, 5'd1, 5'd5, 5'd0, 32'h1000, 32'h3, 32'h8, 1, OP_ADD, 0, 0, 1);
    step();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h99;
    #1;
    checks++; if (alu_in_2 !== 32'h8) $display("FAIL store_in2: got %0h want 8", alu_in_2); else passes++;
    checks++; if (ex_store_data !== 32'h99) $display("FAIL store_data: got %0h want 99", ex_store_data); else passes++;
    checks++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) $display("FAIL store_ctrl: got mw=%0h rw=%0h want 1 0", ex_mem_write, ex_reg_write); else passes++;
    clear_fwd();
    #1;
    checks++; if (ex_store_data !== 32'h3) $display("FAIL store_data_reg: got %0h want 3", ex_store_data); else passes++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_stall_flush();
    test_store();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
